// File: rtl/stream_serializer.sv
// -----------------------------------------------------------------------------
// stream_serializer
//
// Wide-to-narrow stream converter on the REQ/ACK handshake. Each accepted
// input word of ratio*bit_width bits is emitted as `ratio` consecutive beats
// of bit_width bits, and the final beat of each word is flagged with dOutLAST.
// A word can be accepted in the same cycle that the last beat of the previous
// word leaves, so back-to-back words stream without an idle cycle.
//
// Parameters:
//   bit_width  width of one output beat (>= 1)
//   ratio      output beats per input word (>= 1)
//   msb_first  0: beat 0 is the least-significant slice; 1: the most-significant
//
// Ports:
//   clk       in   clock, rising-edge active
//   rst       in   synchronous active-high reset
//   dInREQ    out  ready to accept a word this cycle
//   dInACK    in   upstream word on dIN is valid
//   dIN       in   wide input word (ratio*bit_width bits)
//   dOutACK   out  a beat is valid on dOUT
//   dOutREQ   in   downstream accepts the beat this cycle
//   dOUT      out  current beat (0 when no beat is valid)
//   dOutLAST  out  current beat is the last one of its word
// -----------------------------------------------------------------------------
module stream_serializer #(
    parameter int bit_width = 8,
    parameter int ratio     = 4,
    parameter bit msb_first = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          dInREQ,
    input  logic                          dInACK,
    input  logic [ratio*bit_width-1:0]    dIN,
    output logic                          dOutACK,
    input  logic                          dOutREQ,
    output logic [bit_width-1:0]          dOUT,
    output logic                          dOutLAST
);

    localparam int WORD_W = ratio * bit_width;
    // The beat counter keeps at least one bit even when ratio == 1.
    localparam int CW = (ratio > 1) ? $clog2(ratio) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ratio - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WORD_W-1:0]   r_data;
    logic [WORD_W-1:0]   w_data_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;

    logic                w_valid;
    logic                w_last;
    logic                w_in_fire;
    logic                w_out_fire;
    logic [bit_width-1:0] w_sel;
    logic [bit_width-1:0] w_slices [ratio];

    // Slice table in emission order: entry i is the beat sent at counter == i.
    generate
        for (genvar gi = 0; gi < ratio; gi++) begin : g_slice
            if (msb_first) begin : g_msb
                assign w_slices[gi] = r_data[(ratio-1-gi)*bit_width +: bit_width];
            end else begin : g_lsb
                assign w_slices[gi] = r_data[gi*bit_width +: bit_width];
            end
        end
    endgenerate

    // Compare-based mux avoids an out-of-range index when ratio is not a
    // power of two (or is 1).
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < ratio; i++) begin
            if (r_cnt == CW'(i)) begin
                w_sel = w_slices[i];
            end
        end
    end

    assign w_valid    = (r_state == ST_SEND);
    assign w_last     = w_valid && (r_cnt == LAST_IDX);

    // Outputs are forced quiet while reset is asserted, even before the
    // reset edge has cleared the state.
    assign dOutACK    = !rst && w_valid;
    assign dOutLAST   = !rst && w_last;
    assign dOUT       = (!rst && w_valid) ? w_sel : '0;

    // Combinational path from dOutREQ lets a new word load while the last
    // beat of the current word leaves.
    assign dInREQ     = !rst && (!w_valid || (dOutACK && dOutREQ && dOutLAST));

    assign w_in_fire  = dInACK && dInREQ;
    assign w_out_fire = dOutACK && dOutREQ;

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_state_next = ST_SEND;
                    w_data_next  = dIN;
                    w_cnt_next   = '0;
                end
            end
            ST_SEND: begin
                if (w_out_fire) begin
                    if (!w_last) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end else if (w_in_fire) begin
                        w_data_next = dIN;
                        w_cnt_next  = '0;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_data  <= w_data_next;
        end
    end

endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Wide-to-narrow converter on the team's REQ/ACK stream handshake.
- Accepts one word of ratio*bit_width bits per input handshake and emits it as `ratio` consecutive narrow beats, flagging the final beat.
- Acts as the transmit-side counterpart of narrow-to-wide packing. Sits between a wide datapath and a narrow link or buffer stage.

Parameters:
- bit_width, 8, width of one output beat in bits (>=1)
- ratio, 4, output beats per input word (>=1)
- msb_first, 0, 0 = beat 0 is dIN[bit_width-1:0] (LS slice first); 1 = beat 0 is the MS slice

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- dInREQ  output  1  block can accept a word this cycle (ready)
- dInACK  input  1  upstream presents valid word on dIN
- dIN  input  ratio*bit_width  wide input word
- dOutACK  output  1  valid beat present on dOUT
- dOutREQ  input  1  downstream accepts beat this cycle (ready)
- dOUT  output  bit_width  current beat
- dOutLAST  output  1  high with dOutACK on the final beat of a word

Behaviour:
- Handshakes: input fires when dInACK && dInREQ at a rising edge; output fires when dOutACK && dOutREQ. No other condition moves data.
- State:
  - wide holding register
  - beat counter, $clog2(ratio) bits (min 1)
  - valid flag
- Two logical states: IDLE (valid=0) and SEND (valid=1).
- Reset:
  - Sampled on the rising edge while rst=1: valid=0, counter=0, holding register=0.
  - While rst is high: dInREQ=0, dOutACK=0, dOutLAST=0, dOUT=0.
  - Reset mid-word discards the remaining beats; no partial word survives.
- Outputs:
  - dOutACK = valid.
  - dOutLAST = valid && counter==ratio-1.
  - dOUT = selected slice of the holding register, or 0 when valid=0.
- dInREQ = !rst && (!valid || (dOutACK && dOutREQ && dOutLAST)). This combinational path from dOutREQ gives zero-bubble back-to-back words.
- IDLE -> SEND on input fire: register <= dIN, counter <= 0.
- SEND, output fire, not last: counter++.
- SEND, output fire, last, input fire in same cycle: load the new word, counter <= 0, stay in SEND.
- SEND, output fire, last, no input fire: valid <= 0 (IDLE), counter <= 0.
- SEND, no output fire: all state holds; dOUT and dOutLAST stable under backpressure.
- dInACK while dInREQ=0: ignored, no state change. dIN is sampled only on input fire.
- Slice selection for beat index i:
  - msb_first=0: register[i*bit_width +: bit_width]
  - msb_first=1: register[(ratio-1-i)*bit_width +: bit_width]
- Latency: a word accepted at edge k shows beat 0 on dOUT in the cycle after edge k.
- Throughput: one word per `ratio` cycles with dOutREQ held high.
- ratio=1: counter is a constant 0 and dOutLAST = dOutACK. The block then behaves as a single-entry pass buffer.
- Beats are never skipped, duplicated or reordered. The counter never exceeds ratio-1 and wraps only via a word reload or the return to IDLE.

Test Plan:
- Basic order: bit_width=8, ratio=4, msb_first=0, dIN=32'hA1B2C3D4 accepted, dOutREQ=1 -> dOUT D4,C3,B2,A1 on 4 consecutive cycles; dOutLAST only on A1; dOutACK=0 afterwards.
- Back-to-back: 32'h11223344 and 32'h55667788 offered continuously, dOutREQ=1 -> 8 contiguous beats 44,33,22,11,88,77,66,55; dInREQ=1 exactly on the cycles of beat 11 and beat 55; no idle cycle between words.
- Backpressure: dOutREQ=0 for 3 cycles on beat 2 of 32'hA1B2C3D4 -> dOUT stays B2 with dOutACK=1 and dOutLAST=0; dInREQ=0 throughout; sequence resumes B2,A1.
- Ignored input: dInACK=1 with dIN=32'hDEADBEEF during beats 0-2 of a word -> no corruption of the current word; DEADBEEF is accepted only on the last-beat cycle and its beats EF,BE,AD,DE follow.
- Reset mid-word: assert rst for 1 cycle after beat 1 of 32'hA1B2C3D4 -> during rst dInREQ=0 and dOutACK=0; after rst dOutACK=0 and dInREQ=1; the next word 32'h01020304 emits 04,03,02,01.
- Variants:
  - msb_first=1, 32'hA1B2C3D4 -> A1,B2,C3,D4.
  - ratio=1, bit_width=8, bytes 5A,A5 back-to-back with dOutREQ=1 -> one beat each, dOutLAST=1 on both.
